// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the IF/EX memory-port arbiter: request sources, access sizes, grant states.
package mem_bus_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } gnt_state_e;

    // Fixed priority: load/store beats fetch.
    function automatic gnt_state_e arbitrate(input logic inst_req, input logic data_req);
        if (data_req) return GNT_D;
        if (inst_req) return GNT_I;
        return IDLE;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// SRAM-like request/response port: master drives the request, slave answers with addr_ok/data_ok.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [ADDR_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_bus_arbiter_resp_src_fifo.sv
// Small FIFO remembering which master issued each accepted request, so responses route in order.
module resp_src_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Explicit wrap keeps DEPTH==1 legal with a 1-bit pointer.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and load/store, data first,
// with in-order response routing via a source-tracking FIFO.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int OUTS_DEPTH = 2,
    parameter int ADDR_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    mem_bus_arbiter_if.slave    inst,
    mem_bus_arbiter_if.slave    data,
    mem_bus_arbiter_if.master   bus
);
    gnt_state_e state, state_d, gnt, arb;
    logic       fifo_full, fifo_empty, src_head;
    logic       accept, pop;
    logic [$clog2(OUTS_DEPTH+1)-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        arb       = arbitrate(inst.req, data.req);
        gnt       = arb;
        bus.req   = 1'b0;
        bus.wr    = 1'b0;
        bus.size  = 2'd0;
        bus.wstrb = 4'd0;
        bus.addr  = '0;
        bus.wdata = '0;

        // A grant is only held while its master keeps the request up.
        case (state)
            GNT_I:   if (inst.req) gnt = GNT_I;
            GNT_D:   if (data.req) gnt = GNT_D;
            default: gnt = arb;
        endcase
        if (reset) gnt = IDLE;

        case (gnt)
            GNT_I: begin
                bus.addr = inst.addr;
                bus.size = SIZE_WORD;
            end
            GNT_D: begin
                bus.wr    = data.wr;
                bus.size  = data.size;
                bus.wstrb = data.wstrb;
                bus.addr  = data.addr;
                bus.wdata = data.wdata;
            end
            default: ;
        endcase

        bus.req      = (gnt != IDLE) && !fifo_full;
        accept       = bus.req && bus.addr_ok;
        inst.addr_ok = accept && (gnt == GNT_I);
        data.addr_ok = accept && (gnt == GNT_D);
        state_d      = accept ? arb : gnt;

        // Responses with nothing outstanding (e.g. after reset) are swallowed.
        pop          = bus.data_ok && !fifo_empty && !reset;
        inst.data_ok = pop && (src_head == SRC_INST);
        data.data_ok = pop && (src_head == SRC_DATA);
        inst.rdata   = bus.rdata;
        data.rdata   = bus.rdata;
    end

    resp_src_fifo #(
        .DEPTH (OUTS_DEPTH),
        .WIDTH (1)
    ) u_src_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   ((gnt == GNT_D) ? SRC_DATA : SRC_INST),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (src_head),
        .count (count)
    );

endmodule
